// File: rtl/udma_eth_pkg.sv
// Shared types for the uDMA Ethernet RX ring scheduler: FSM states, descriptor record, default buffer size.
package udma_eth_pkg;

   localparam int unsigned BUF_SIZE_DEF = 1536;
   localparam int unsigned DESC_LEN_W   = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ARM,
      S_RECV,
      S_COMMIT,
      S_STALL
   } rx_state_e;

   typedef struct packed {
      logic                  err;
      logic [DESC_LEN_W-1:0] len;
   } desc_t;

endpackage

// File: rtl/udma_eth_rx_ring_sched.sv
// RX buffer ring scheduler: arms the uDMA RX channel with the next free buffer, writes back a descriptor per frame.
// ch_en_o lands >=2 cycles after a free buffer is found; holds in ARM while ch_ready_i=0, stalls on busy buffers.
module udma_eth_rx_ring_sched
   import udma_eth_pkg::*;
#(
   parameter  int unsigned L2_AWIDTH_NOAL = 12,
   parameter  int unsigned TRANS_SIZE     = 16,
   parameter  int unsigned NBUF           = 4,
   parameter  int unsigned BUF_SIZE       = BUF_SIZE_DEF,
   localparam int unsigned IDX_W          = $clog2(NBUF)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           enable_i,
   input  logic [NBUF*L2_AWIDTH_NOAL-1:0] buf_addr_i,
   input  logic [NBUF-1:0]                buf_busy_i,
   output logic [L2_AWIDTH_NOAL-1:0]      ch_startaddr_o,
   output logic [TRANS_SIZE-1:0]          ch_size_o,
   output logic                           ch_en_o,
   input  logic                           ch_ready_i,
   input  logic                           frame_done_i,
   input  logic [TRANS_SIZE-1:0]          frame_len_i,
   input  logic                           frame_err_i,
   output logic                           desc_wr_o,
   output logic [IDX_W-1:0]               desc_idx_o,
   output logic [TRANS_SIZE-1:0]          desc_len_o,
   output logic                           desc_err_o,
   input  logic                           irq_en_i,
   output logic                           rx_irq_o,
   output logic [IDX_W-1:0]               cur_idx_o,
   output logic                           stall_o,
   output logic [15:0]                    drop_cnt_o
);

   localparam logic [TRANS_SIZE-1:0] BUF_SIZE_T = TRANS_SIZE'(BUF_SIZE);

   rx_state_e                   state_q, state_d;
   logic [IDX_W-1:0]            ptr_q;
   desc_t                       desc_q;
   logic [L2_AWIDTH_NOAL-1:0]   addr_sel;
   logic                        too_long;

   always_comb begin
      addr_sel = '0;
      for (int k = 0; k < NBUF; k++) begin
         if (ptr_q == IDX_W'(k)) addr_sel = buf_addr_i[k*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
      end
   end

   assign too_long = frame_len_i > BUF_SIZE_T;

   // Strict in-order ring: a busy buffer blocks rather than being skipped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (enable_i) state_d = S_CHECK;
         S_CHECK: begin
            if (!enable_i)               state_d = S_IDLE;
            else if (buf_busy_i[ptr_q])  state_d = S_STALL;
            else                         state_d = S_ARM;
         end
         S_ARM:    if (ch_ready_i) state_d = S_RECV;
         S_RECV:   if (frame_done_i) state_d = S_COMMIT;
         S_COMMIT: state_d = enable_i ? S_CHECK : S_IDLE;
         S_STALL: begin
            if (!enable_i)               state_d = S_IDLE;
            else if (!buf_busy_i[ptr_q]) state_d = S_ARM;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         ptr_q          <= '0;
         ch_startaddr_o <= '0;
         ch_size_o      <= '0;
         ch_en_o        <= 1'b0;
         desc_q         <= '0;
      end else begin
         state_q <= state_d;
         ch_en_o <= (state_q == S_ARM) && ch_ready_i;
         if (state_q == S_ARM) begin
            ch_startaddr_o <= addr_sel;
            ch_size_o      <= BUF_SIZE_T;
         end
         if ((state_q == S_RECV) && frame_done_i) begin
            desc_q.len <= DESC_LEN_W'(too_long ? BUF_SIZE_T : frame_len_i);
            desc_q.err <= frame_err_i | too_long;
         end
         if (state_q == S_COMMIT) ptr_q <= ptr_q + IDX_W'(1);
      end
   end

   // Drops are counted even on the cycle the stalled buffer frees up.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_cnt_o <= '0;
      end else if ((state_q == S_STALL) && frame_done_i && (drop_cnt_o != 16'hFFFF)) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end

   assign desc_wr_o  = (state_q == S_COMMIT);
   assign desc_idx_o = ptr_q;
   assign desc_len_o = TRANS_SIZE'(desc_q.len);
   assign desc_err_o = desc_q.err;
   assign rx_irq_o   = desc_wr_o & irq_en_i;
   assign cur_idx_o  = ptr_q;
   assign stall_o    = (state_q == S_STALL);

endmodule

// File: doc/udma_eth_rx_ring_sched.md
Name: udma_eth_rx_ring_sched

Overview:
Receive-buffer ring scheduler for the uDMA Ethernet RX channel.
- Rotates the RX channel through NBUF software-provided L2 buffers.
- Arms the channel with the next free buffer, waits for end-of-frame, then writes back a descriptor (index, length, error) and advances the ring.
- Sits between the Ethernet register interface (buffer addresses, ownership flags) and the uDMA RX channel configuration.

Parameters:
- L2_AWIDTH_NOAL, 12, L2 address width.
- TRANS_SIZE, 16, transfer length width.
- NBUF, 4, ring depth; power of two, 2..8; IDX_W = $clog2(NBUF).
- BUF_SIZE, 1536, per-buffer byte capacity, programmed as the channel size.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- enable_i  in  1  ring enable (level).
- buf_addr_i  in  NBUF*L2_AWIDTH_NOAL  buffer start addresses; entry k at [k*AW +: AW].
- buf_busy_i  in  NBUF  1 = buffer owned by SW (not free).
- ch_startaddr_o  out  L2_AWIDTH_NOAL  RX channel start address.
- ch_size_o  out  TRANS_SIZE  RX channel size.
- ch_en_o  out  1  one-cycle channel enable pulse.
- ch_ready_i  in  1  channel idle, can accept ch_en_o.
- frame_done_i  in  1  end-of-frame pulse from the MAC side.
- frame_len_i  in  TRANS_SIZE  frame byte count; valid with frame_done_i.
- frame_err_i  in  1  bad frame/FCS flag; valid with frame_done_i.
- desc_wr_o  out  1  descriptor write-back pulse.
- desc_idx_o  out  IDX_W  buffer index written back.
- desc_len_o  out  TRANS_SIZE  stored length.
- desc_err_o  out  1  frame error or truncation.
- irq_en_i  in  1  RX interrupt enable.
- rx_irq_o  out  1  one-cycle pulse per committed frame when enabled.
- cur_idx_o  out  IDX_W  ring pointer.
- stall_o  out  1  waiting for a free buffer.
- drop_cnt_o  out  16  saturating count of frames dropped while stalled.

Behaviour:
- Reset (rst_i sampled high at posedge): FSM=IDLE, ptr=0, drop_cnt=0, all outputs 0. Applies in any state; an in-flight frame is abandoned with no write-back.
- IDLE: when enable_i=1, go to CHECK.
- CHECK (1 cycle):
  - buf_busy_i[ptr]=0 -> ARM.
  - buf_busy_i[ptr]=1 -> STALL.
  - enable_i=0 -> IDLE.
- ARM:
  - ch_startaddr_o = buf_addr_i[ptr], ch_size_o = BUF_SIZE, registered.
  - ch_en_o=1 for exactly one cycle, in the cycle ch_ready_i=1; then -> RECV.
  - Hold in ARM while ch_ready_i=0.
  - Latency: free buffer seen in CHECK -> ch_en_o no earlier than 2 cycles later.
- RECV:
  - Wait for frame_done_i; capture len/err, then -> COMMIT.
  - enable_i falling in RECV does not abort; the frame completes and commits.
- COMMIT (1 cycle):
  - desc_wr_o=1 with desc_idx_o=ptr.
  - desc_len_o = min(frame_len_i, BUF_SIZE).
  - desc_err_o = frame_err_i | (frame_len_i > BUF_SIZE).
  - rx_irq_o = irq_en_i.
  - ptr <= ptr+1, wrapping NBUF-1 -> 0.
  - Next state: enable_i ? CHECK : IDLE.
- STALL:
  - stall_o=1.
  - Each frame_done_i increments drop_cnt, saturating at 16'hFFFF.
  - buf_busy_i[ptr] falls -> ARM; stall_o drops the same cycle ARM is entered.
  - enable_i=0 -> IDLE, stall_o=0.
  - A drop and a buffer free in the same cycle: count the drop, then go to ARM.
- The pointer never skips a busy buffer; strict in-order ring. A frame_done_i outside RECV/STALL is ignored.
- Outputs ch_startaddr_o/ch_size_o hold their last values outside ARM; pulse outputs are 0 otherwise.

Decomposition:
- Shared package udma_eth_pkg: FSM enum (IDLE, CHECK, ARM, RECV, COMMIT, STALL), descriptor struct {err, len}, BUF_SIZE default constant.
- No sub-module needed. The saturating drop counter may be an internal always_ff block.

Test Plan:
- All buffers free, enable_i=1, four frames of len 64/128/256/60 -> desc_wr_o idx 0,1,2,3 with matching lengths, ptr wraps to 0, four rx_irq_o pulses.
- buf_busy_i=4'b0010, frame committed at idx 0 -> stall_o=1 at idx 1; three frame_done_i -> drop_cnt_o=3; clear busy -> ch_en_o with buf_addr[1] within 2 cycles.
- frame_len_i=2000, BUF_SIZE=1536 -> desc_len_o=1536, desc_err_o=1; frame_err_i=1 len 64 -> desc_len_o=64, desc_err_o=1.
- ch_ready_i held low 5 cycles in ARM -> no ch_en_o; ch_ready_i high -> exactly one ch_en_o pulse.
- enable_i dropped mid-RECV -> frame still commits, FSM returns to IDLE; rst_i asserted mid-RECV -> no desc_wr_o, ptr=0, drop_cnt_o=0, all outputs 0 next cycle.
- irq_en_i=0 -> commits produce desc_wr_o but no rx_irq_o.
